// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared encodings and constants for the branch resolver
package branch_resolver_pkg;
  localparam int OP_W = 2;
  localparam int PC_INC = 4;
  typedef enum logic [OP_W-1:0] {
    OP_NONE   = 2'd0,
    OP_JAL    = 2'd1,
    OP_JALR   = 2'd2,
    OP_BRANCH = 2'd3
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_e;
endpackage

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: EX-side resolve inputs, predictor feedback, redirect and statistics
interface branch_resolver_if
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              valid_i;
  logic [OP_W-1:0]   op_i;
  logic [ADDR_W-1:0] pc_i;
  logic [ADDR_W-1:0] target_i;
  logic              cond_i;
  logic              pred_taken_i;
  logic [ADDR_W-1:0] pred_target_i;
  logic              jump_ack_i;
  logic              is_branch_o;
  logic              branch_taken_o;
  logic [ADDR_W-1:0] branch_pc_o;
  logic [ADDR_W-1:0] branch_target_o;
  logic              jump_enable_o;
  logic [ADDR_W-1:0] jump_pc_o;
  logic              flush_o;
  logic              busy_o;
  logic [CNT_W-1:0]  branch_cnt_o;
  logic [CNT_W-1:0]  mispred_cnt_o;
  modport master (
    output valid_i, op_i, pc_i, target_i, cond_i, pred_taken_i, pred_target_i, jump_ack_i,
    input  is_branch_o, branch_taken_o, branch_pc_o, branch_target_o, jump_enable_o,
           jump_pc_o, flush_o, busy_o, branch_cnt_o, mispred_cnt_o
  );
  modport slave (
    input  valid_i, op_i, pc_i, target_i, cond_i, pred_taken_i, pred_target_i, jump_ack_i,
    output is_branch_o, branch_taken_o, branch_pc_o, branch_target_o, jump_enable_o,
           jump_pc_o, flush_o, busy_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_resolver_sat_counter.sv
// sat_counter: event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  // count up on inc_i unless saturated; active-low sync clear
  always_ff @(posedge clk)
    cnt_q <= !rst ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves EX control flow, feeds the predictor and redirects fetch on mispredict
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  branch_resolver_if.slave br
);
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  state_e            state_q, state_d;
  logic              is_branch_q, is_branch_d, taken_q, taken_d;
  logic              jen_q, jen_d, flush_q, flush_d, busy_q, busy_d;
  logic [ADDR_W-1:0] bpc_q, bpc_d, btgt_q, btgt_d, jpc_q, jpc_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  op_e               op;
  logic              actual_taken, mispredict, accept, is_fb;
  logic [ADDR_W-1:0] redirect_pc;
  // decode the resolved instruction against its prediction
  always_comb begin
    op           = op_e'(br.op_i);
    actual_taken = op == OP_BRANCH ? br.cond_i : op != OP_NONE;
    mispredict   = op == OP_JALR || (op != OP_NONE && (actual_taken != br.pred_taken_i ||
                   (actual_taken && br.pred_target_i != br.target_i)));
    redirect_pc  = actual_taken ? br.target_i : br.pc_i + ADDR_W'(PC_INC);
    accept       = rdy && br.valid_i && state_q == S_IDLE && op != OP_NONE;
    is_fb        = accept && (op == OP_JAL || op == OP_BRANCH);
  end
  // next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    is_branch_d = 1'b0;
    taken_d     = taken_q;
    bpc_d       = bpc_q;
    btgt_d      = btgt_q;
    jen_d       = jen_q;
    jpc_d       = jpc_q;
    flush_d     = flush_q;
    busy_d      = busy_q;
    fcnt_d      = fcnt_q;
    if (state_q == S_IDLE) begin
      if (is_fb) begin
        is_branch_d = 1'b1;
        taken_d     = actual_taken;
        bpc_d       = br.pc_i;
        btgt_d      = br.target_i;
      end
      jen_d   = accept && mispredict;
      flush_d = accept && mispredict;
      busy_d  = accept && mispredict;
      if (accept && mispredict) begin
        state_d = S_REDIRECT;
        jpc_d   = redirect_pc;
      end
    end else if (state_q == S_REDIRECT) begin
      if (br.jump_ack_i) begin
        jen_d = 1'b0;
        if (FLUSH_CYCLES > 0) begin
          state_d = S_FLUSH;
          fcnt_d  = FW'(FLUSH_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
          flush_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
    end else begin
      fcnt_d = fcnt_q - FW'(1);
      if (fcnt_q == '0) begin
        state_d = S_IDLE;
        flush_d = 1'b0;
        busy_d  = 1'b0;
      end
    end
  end
  // state and output registers; rdy low freezes, reset wins over rdy
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      is_branch_q <= 1'b0;
      taken_q     <= 1'b0;
      bpc_q       <= '0;
      btgt_q      <= '0;
      jen_q       <= 1'b0;
      jpc_q       <= '0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      fcnt_q      <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      is_branch_q <= is_branch_d;
      taken_q     <= taken_d;
      bpc_q       <= bpc_d;
      btgt_q      <= btgt_d;
      jen_q       <= jen_d;
      jpc_q       <= jpc_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      fcnt_q      <= fcnt_d;
    end
  end
  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk(clk), .rst(rst), .inc_i(is_fb), .cnt_o(br.branch_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .clk(clk), .rst(rst), .inc_i(accept && mispredict), .cnt_o(br.mispred_cnt_o)
  );
  assign br.is_branch_o     = is_branch_q;
  assign br.branch_taken_o  = taken_q;
  assign br.branch_pc_o     = bpc_q;
  assign br.branch_target_o = btgt_q;
  assign br.jump_enable_o   = jen_q;
  assign br.jump_pc_o       = jpc_q;
  assign br.flush_o         = flush_q;
  assign br.busy_o          = busy_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: randomized and directed checks of branch_resolver against a transaction model
module tb_branch_resolver;
  import branch_resolver_pkg::*;
  localparam int FC = 2;
  localparam int CMAX = 15;
  logic clk, rst, rdy;
  int nvec, nfail, m_br, m_mp;
  branch_resolver_if #(.ADDR_W(32), .CNT_W(4)) bus ();
  branch_resolver #(.ADDR_W(32), .FLUSH_CYCLES(FC), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .br(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int c);
    return c >= CMAX ? CMAX : c + 1;
  endfunction
  function automatic bit m_taken(input logic [1:0] op, input logic cond);
    return op == OP_BRANCH ? cond : op != OP_NONE;
  endfunction
  function automatic bit m_mispred(input logic [1:0] op, input logic cond, input logic pt,
                                   input logic [31:0] ptgt, input logic [31:0] tgt);
    bit t;
    t = m_taken(op, cond);
    if (op == OP_NONE) return 0;
    if (op == OP_JALR) return 1;
    return t != pt || (t && ptgt != tgt);
  endfunction
  function automatic logic [31:0] m_redirect(input logic [1:0] op, input logic cond,
                                            input logic [31:0] pc, input logic [31:0] tgt);
    return m_taken(op, cond) ? tgt : pc + 32'd4;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic cond, input logic pt, input logic [31:0] ptgt);
    bus.valid_i = 1'b1; bus.op_i = op; bus.pc_i = pc; bus.target_i = tgt;
    bus.cond_i = cond; bus.pred_taken_i = pt; bus.pred_target_i = ptgt;
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic cond, input logic pt, input logic [31:0] ptgt);
    drive(op, pc, tgt, cond, pt, ptgt);
    tick;
    bus.valid_i = 1'b0;
    if (rdy) begin
      if (op == OP_JAL || op == OP_BRANCH) m_br = sat(m_br);
      if (m_mispred(op, cond, pt, ptgt, tgt)) m_mp = sat(m_mp);
    end
  endtask
  task automatic finish_redirect;
    bus.jump_ack_i = 1'b1;
    tick;
    bus.jump_ack_i = 1'b0;
    repeat (FC) tick;
  endtask

  task automatic test_reset;
    rst = 1'b0; rdy = 1'b0;
    repeat (2) tick;
    nvec++;
    if ({bus.is_branch_o, bus.branch_taken_o, bus.jump_enable_o, bus.flush_o, bus.busy_o} !== 5'b0) begin
      nfail++; $display("FAIL reset_flags: got %b want 00000",
        {bus.is_branch_o, bus.branch_taken_o, bus.jump_enable_o, bus.flush_o, bus.busy_o});
    end
    nvec++;
    if ({bus.branch_pc_o, bus.branch_target_o, bus.jump_pc_o, bus.branch_cnt_o, bus.mispred_cnt_o} !== 104'b0) begin
      nfail++; $display("FAIL reset_values: pc %h tgt %h jpc %h cnt %0d/%0d want all 0",
        bus.branch_pc_o, bus.branch_target_o, bus.jump_pc_o, bus.branch_cnt_o, bus.mispred_cnt_o);
    end
    rst = 1'b1; rdy = 1'b1; m_br = 0; m_mp = 0;
    tick;
    nvec++;
    if ({bus.jump_enable_o, bus.flush_o, bus.busy_o} !== 3'b0) begin
      nfail++; $display("FAIL reset_release: got %b want 000", {bus.jump_enable_o, bus.flush_o, bus.busy_o});
    end
  endtask

  task automatic test_predicted_branch;
    issue(OP_BRANCH, 32'h100, 32'h140, 1'b1, 1'b1, 32'h140);
    nvec++;
    if ({bus.is_branch_o, bus.branch_taken_o, bus.jump_enable_o, bus.flush_o, bus.busy_o} !== 5'b11000) begin
      nfail++; $display("FAIL pred_flags: got %b want 11000",
        {bus.is_branch_o, bus.branch_taken_o, bus.jump_enable_o, bus.flush_o, bus.busy_o});
    end
    nvec++;
    if ({bus.branch_pc_o, bus.branch_target_o} !== {32'h100, 32'h140}) begin
      nfail++; $display("FAIL pred_fb: got %h/%h want 100/140", bus.branch_pc_o, bus.branch_target_o);
    end
    nvec++;
    if ({bus.branch_cnt_o, bus.mispred_cnt_o} !== 8'h10) begin
      nfail++; $display("FAIL pred_cnt: got %0d/%0d want 1/0", bus.branch_cnt_o, bus.mispred_cnt_o);
    end
    tick;
    nvec++;
    if (bus.is_branch_o !== 1'b0) begin
      nfail++; $display("FAIL pred_pulse: is_branch %b want 0 on second cycle", bus.is_branch_o);
    end
  endtask

  task automatic test_mispredict_flush;
    issue(OP_BRANCH, 32'h200, 32'h240, 1'b0, 1'b1, 32'h240);
    nvec++;
    if ({bus.is_branch_o, bus.branch_taken_o, bus.jump_enable_o, bus.flush_o, bus.busy_o, bus.jump_pc_o} !==
        {5'b10111, 32'h204}) begin
      nfail++; $display("FAIL mp_start: flags %b jpc %h want 10111 204",
        {bus.is_branch_o, bus.branch_taken_o, bus.jump_enable_o, bus.flush_o, bus.busy_o}, bus.jump_pc_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      nvec++;
      if ({bus.jump_enable_o, bus.jump_pc_o} !== {1'b1, 32'h204}) begin
        nfail++; $display("FAIL mp_hold%0d: jen %b jpc %h want 1 204", i, bus.jump_enable_o, bus.jump_pc_o);
      end
    end
    bus.jump_ack_i = 1'b1;
    tick;
    bus.jump_ack_i = 1'b0;
    for (int i = 0; i <= FC; i++) begin
      nvec++;
      if ({bus.jump_enable_o, bus.flush_o, bus.busy_o} !== (i < FC ? 3'b011 : 3'b000)) begin
        nfail++; $display("FAIL mp_flush%0d: got %b want %b", i,
          {bus.jump_enable_o, bus.flush_o, bus.busy_o}, i < FC ? 3'b011 : 3'b000);
      end
      if (i < FC) tick;
    end
    nvec++;
    if ({bus.branch_cnt_o, bus.mispred_cnt_o} !== {4'(m_br), 4'(m_mp)}) begin
      nfail++; $display("FAIL mp_cnt: got %0d/%0d want %0d/%0d", bus.branch_cnt_o, bus.mispred_cnt_o, m_br, m_mp);
    end
  endtask

  task automatic test_jalr;
    issue(OP_JALR, 32'h300, 32'h80, 1'b0, 1'b1, 32'h80);
    nvec++;
    if ({bus.is_branch_o, bus.jump_enable_o, bus.jump_pc_o} !== {2'b01, 32'h80}) begin
      nfail++; $display("FAIL jalr: is_branch %b jen %b jpc %h want 0 1 80",
        bus.is_branch_o, bus.jump_enable_o, bus.jump_pc_o);
    end
    nvec++;
    if ({bus.branch_cnt_o, bus.mispred_cnt_o} !== {4'(m_br), 4'(m_mp)}) begin
      nfail++; $display("FAIL jalr_cnt: got %0d/%0d want %0d/%0d", bus.branch_cnt_o, bus.mispred_cnt_o, m_br, m_mp);
    end
    finish_redirect;
  endtask

  task automatic test_jal;
    issue(OP_JAL, 32'h400, 32'h500, 1'b0, 1'b1, 32'h480);
    nvec++;
    if ({bus.is_branch_o, bus.branch_taken_o, bus.branch_pc_o, bus.branch_target_o, bus.jump_enable_o, bus.jump_pc_o} !==
        {2'b11, 32'h400, 32'h500, 1'b1, 32'h500}) begin
      nfail++; $display("FAIL jal: fb %b%b %h->%h jen %b jpc %h want 11 400->500 1 500", bus.is_branch_o,
        bus.branch_taken_o, bus.branch_pc_o, bus.branch_target_o, bus.jump_enable_o, bus.jump_pc_o);
    end
    nvec++;
    if ({bus.branch_cnt_o, bus.mispred_cnt_o} !== {4'(m_br), 4'(m_mp)}) begin
      nfail++; $display("FAIL jal_cnt: got %0d/%0d want %0d/%0d", bus.branch_cnt_o, bus.mispred_cnt_o, m_br, m_mp);
    end
    finish_redirect;
  endtask

  task automatic test_discard_freeze;
    issue(OP_BRANCH, 32'h600, 32'h700, 1'b1, 1'b0, 32'h0);
    drive(OP_JAL, 32'h800, 32'h900, 1'b0, 1'b0, 32'h0);
    tick;
    bus.valid_i = 1'b0;
    rdy = 1'b0; bus.jump_ack_i = 1'b1; bus.valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if ({bus.is_branch_o, bus.jump_enable_o, bus.flush_o, bus.busy_o, bus.jump_pc_o,
           bus.branch_cnt_o, bus.mispred_cnt_o} !== {4'b0111, 32'h700, 4'(m_br), 4'(m_mp)}) begin
        nfail++; $display("FAIL freeze%0d: flags %b jpc %h cnt %0d/%0d want 0111 700 %0d/%0d", i,
          {bus.is_branch_o, bus.jump_enable_o, bus.flush_o, bus.busy_o}, bus.jump_pc_o,
          bus.branch_cnt_o, bus.mispred_cnt_o, m_br, m_mp);
      end
      if (i < 4) tick;
    end
    rdy = 1'b1; bus.jump_ack_i = 1'b0; bus.valid_i = 1'b0;
    tick;
    nvec++;
    if ({bus.jump_enable_o, bus.jump_pc_o} !== {1'b1, 32'h700}) begin
      nfail++; $display("FAIL resume: jen %b jpc %h want 1 700", bus.jump_enable_o, bus.jump_pc_o);
    end
    finish_redirect;
    rdy = 1'b0;
    drive(OP_JAL, 32'hA00, 32'hB00, 1'b0, 1'b1, 32'hB00);
    repeat (2) tick;
    nvec++;
    if ({bus.is_branch_o, bus.branch_cnt_o} !== {1'b0, 4'(m_br)}) begin
      nfail++; $display("FAIL stall_accept: is_branch %b cnt %0d want 0 %0d", bus.is_branch_o, bus.branch_cnt_o, m_br);
    end
    rdy = 1'b1;
    issue(OP_JAL, 32'hA00, 32'hB00, 1'b0, 1'b1, 32'hB00);
    tick;
    nvec++;
    if ({bus.is_branch_o, bus.branch_cnt_o, bus.jump_enable_o} !== {1'b0, 4'(m_br), 1'b0}) begin
      nfail++; $display("FAIL single_pulse: is_branch %b cnt %0d jen %b want 0 %0d 0",
        bus.is_branch_o, bus.branch_cnt_o, bus.jump_enable_o, m_br);
    end
  endtask

  task automatic test_random;
    logic [1:0] op;
    logic [31:0] pc, tgt, ptgt;
    logic cond, pt;
    bit fb, mp;
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      pc = $urandom & ~32'h3;
      if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFFC;
      tgt = $urandom & ~32'h3;
      cond = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      ptgt = $urandom_range(0, 1) == 1 ? tgt : tgt ^ 32'h10;
      if ($urandom_range(0, 3) == 0) begin
        rdy = 1'b0;
        drive(op, pc, tgt, cond, pt, ptgt);
        tick;
        nvec++;
        if ({bus.jump_enable_o, bus.branch_cnt_o, bus.mispred_cnt_o} !== {1'b0, 4'(m_br), 4'(m_mp)}) begin
          nfail++; $display("FAIL rnd_stall%0d: jen %b cnt %0d/%0d want 0 %0d/%0d", i,
            bus.jump_enable_o, bus.branch_cnt_o, bus.mispred_cnt_o, m_br, m_mp);
        end
        rdy = 1'b1;
      end
      issue(op, pc, tgt, cond, pt, ptgt);
      fb = op == OP_JAL || op == OP_BRANCH;
      mp = m_mispred(op, cond, pt, ptgt, tgt);
      nvec++;
      if (bus.is_branch_o !== fb || (fb && {bus.branch_taken_o, bus.branch_pc_o, bus.branch_target_o} !==
          {m_taken(op, cond), pc, tgt})) begin
        nfail++; $display("FAIL rnd_fb%0d: op %0d got %b %b %h %h want %b %b %h %h", i, op, bus.is_branch_o,
          bus.branch_taken_o, bus.branch_pc_o, bus.branch_target_o, fb, m_taken(op, cond), pc, tgt);
      end
      nvec++;
      if ({bus.jump_enable_o, bus.flush_o, bus.busy_o} !== {mp, mp, mp} ||
          (mp && bus.jump_pc_o !== m_redirect(op, cond, pc, tgt))) begin
        nfail++; $display("FAIL rnd_redir%0d: op %0d got %b %h want %b %h", i, op,
          {bus.jump_enable_o, bus.flush_o, bus.busy_o}, bus.jump_pc_o, {mp, mp, mp}, m_redirect(op, cond, pc, tgt));
      end
      nvec++;
      if ({bus.branch_cnt_o, bus.mispred_cnt_o} !== {4'(m_br), 4'(m_mp)}) begin
        nfail++; $display("FAIL rnd_cnt%0d: got %0d/%0d want %0d/%0d", i,
          bus.branch_cnt_o, bus.mispred_cnt_o, m_br, m_mp);
      end
      if (mp) begin
        repeat ($urandom_range(0, 3)) begin
          rdy = 1'($urandom_range(0, 1));
          drive(OP_BRANCH, $urandom, $urandom, 1'b1, 1'b0, 32'h0);
          tick;
          bus.valid_i = 1'b0;
          nvec++;
          if ({bus.jump_enable_o, bus.flush_o, bus.jump_pc_o, bus.mispred_cnt_o} !==
              {2'b11, m_redirect(op, cond, pc, tgt), 4'(m_mp)}) begin
            nfail++; $display("FAIL rnd_hold%0d: jen %b flush %b jpc %h mp %0d want 1 1 %h %0d", i,
              bus.jump_enable_o, bus.flush_o, bus.jump_pc_o, bus.mispred_cnt_o, m_redirect(op, cond, pc, tgt), m_mp);
          end
        end
        rdy = 1'b1;
        bus.jump_ack_i = 1'b1;
        tick;
        bus.jump_ack_i = 1'b0;
        repeat (FC) tick;
        nvec++;
        if ({bus.jump_enable_o, bus.flush_o, bus.busy_o} !== 3'b000) begin
          nfail++; $display("FAIL rnd_done%0d: got %b want 000", i, {bus.jump_enable_o, bus.flush_o, bus.busy_o});
        end
      end
    end
  endtask

  task automatic test_reset_mid_flush;
    for (int i = 0; i < 20 && (m_br < CMAX || m_mp < CMAX); i++) begin
      issue(OP_JAL, 32'h1000, 32'h2000, 1'b0, 1'b0, 32'h0);
      finish_redirect;
    end
    issue(OP_JAL, 32'h1000, 32'h2000, 1'b0, 1'b0, 32'h0);
    bus.jump_ack_i = 1'b1;
    tick;
    bus.jump_ack_i = 1'b0;
    nvec++;
    if ({bus.jump_enable_o, bus.flush_o, bus.busy_o, bus.branch_cnt_o, bus.mispred_cnt_o} !== {3'b011, 8'hFF}) begin
      nfail++; $display("FAIL sat_flush: flags %b cnt %0d/%0d want 011 15/15",
        {bus.jump_enable_o, bus.flush_o, bus.busy_o}, bus.branch_cnt_o, bus.mispred_cnt_o);
    end
    rst = 1'b0;
    tick;
    nvec++;
    if ({bus.is_branch_o, bus.jump_enable_o, bus.flush_o, bus.busy_o, bus.jump_pc_o,
         bus.branch_cnt_o, bus.mispred_cnt_o} !== 44'b0) begin
      nfail++; $display("FAIL rst_flush: flags %b jpc %h cnt %0d/%0d want 0000 0 0/0",
        {bus.is_branch_o, bus.jump_enable_o, bus.flush_o, bus.busy_o}, bus.jump_pc_o,
        bus.branch_cnt_o, bus.mispred_cnt_o);
    end
    rst = 1'b1; m_br = 0; m_mp = 0;
    bus.jump_ack_i = 1'b1;
    repeat (3) tick;
    bus.jump_ack_i = 1'b0;
    nvec++;
    if ({bus.jump_enable_o, bus.flush_o, bus.busy_o} !== 3'b000) begin
      nfail++; $display("FAIL rst_abandon: got %b want 000", {bus.jump_enable_o, bus.flush_o, bus.busy_o});
    end
  endtask

  initial begin
    nvec = 0; nfail = 0; m_br = 0; m_mp = 0;
    rst = 1'b0; rdy = 1'b1;
    bus.valid_i = 1'b0; bus.op_i = '0; bus.pc_i = '0; bus.target_i = '0;
    bus.cond_i = 1'b0; bus.pred_taken_i = 1'b0; bus.pred_target_i = '0; bus.jump_ack_i = 1'b0;
    test_reset;
    test_predicted_branch;
    test_mispredict_flush;
    test_jalr;
    test_jal;
    test_discard_freeze;
    test_random;
    test_reset_mid_flush;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address/PC width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning post-redirect flush length in cycles (0 allowed).
REQ-003 SHALL have parameter CNT_W, default 32, meaning statistics counter width.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 rdy  input  1  global ready; low freezes all state and counters.
REQ-007 valid_i  input  1  resolved control-flow instruction present from EX.
REQ-008 op_i  input  2  0=none, 1=JAL, 2=JALR, 3=BRANCH.
REQ-009 pc_i  input  ADDR_W  PC of the instruction.
REQ-010 target_i  input  ADDR_W  computed taken target.
REQ-011 cond_i  input  1  branch condition true (BRANCH only).
REQ-012 pred_taken_i, pred_target_i  input  1, ADDR_W  prediction carried from fetch.
REQ-013 is_branch_o, branch_taken_o  output  1, 1  predictor feedback pulse, taken flag.
REQ-014 branch_pc_o, branch_target_o  output  ADDR_W  feedback PC and target.
REQ-015 jump_enable_o, jump_pc_o  output  1, ADDR_W  redirect request and destination.
REQ-016 jump_ack_i  input  1  fetch accepted the redirect this cycle.
REQ-017 flush_o  output  1  kill wrong-path instructions in IF/ID.
REQ-018 busy_o  output  1  upstream stall; valid_i ignored while high.
REQ-019 branch_cnt_o, mispred_cnt_o  output  CNT_W  resolved JAL/BRANCH count, mispredict count.

Function
REQ-020 SHALL implement FSM states IDLE, REDIRECT, FLUSH; all outputs registered.
REQ-021 actual_taken SHALL be 1 for JAL/JALR, cond_i for BRANCH.
REQ-022 mispredict SHALL be (actual_taken != pred_taken_i) or (actual_taken and pred_target_i != target_i); JALR always mispredicts.
REQ-023 redirect PC SHALL be target_i if actual_taken, else pc_i+4 modulo 2^ADDR_W.
REQ-024 In IDLE with valid_i and op_i in {JAL, BRANCH}, is_branch_o SHALL pulse exactly one cycle at edge N+1, with branch_taken_o=actual_taken, branch_pc_o=pc_i, branch_target_o=target_i.
REQ-025 JALR and op_i=0 SHALL NOT produce is_branch_o.
REQ-026 On mispredict in IDLE, at N+1: state=REDIRECT, jump_enable_o=1, jump_pc_o=redirect PC, flush_o=1, busy_o=1.
REQ-027 In REDIRECT, jump_enable_o and jump_pc_o SHALL hold stable until a cycle with jump_ack_i=1; jump_ack_i outside REDIRECT ignored.
REQ-028 On ack: jump_enable_o=0 next edge; FLUSH_CYCLES>0 -> FLUSH with flush_o=1, busy_o=1 for exactly FLUSH_CYCLES cycles then IDLE; FLUSH_CYCLES=0 -> IDLE directly.
REQ-029 Correct prediction SHALL leave state IDLE, flush_o=0, busy_o=0.
REQ-030 valid_i in REDIRECT or FLUSH SHALL be discarded (no feedback, no count).
REQ-031 branch_cnt_o SHALL increment per accepted JAL/BRANCH; mispred_cnt_o per accepted mispredict (JALR included); both saturate at all-ones.
REQ-032 rdy=0 SHALL hold state, outputs and counters, including mid-REDIRECT; is_branch_o pulse SHALL not repeat.

Reset
REQ-033 rst=0 at an edge SHALL force IDLE, all 1-bit outputs 0, all address outputs 0, counters 0, regardless of rdy or current state.
REQ-034 Reset during REDIRECT/FLUSH SHALL abandon the redirect; no jump_enable_o after release until a new mispredict.

Structure
REQ-035 op_i encodings, FSM state encoding and the +4 increment constant SHALL live in the shared package.
REQ-036 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice.

Verification
REQ-037 BRANCH pc=0x100, target=0x140, cond=1, pred_taken=1, pred_target=0x140 -> one is_branch_o pulse, taken=1, no jump, branch_cnt=1, mispred_cnt=0.
REQ-038 BRANCH pc=0x200, cond=0, pred_taken=1 -> jump_pc_o=0x204 held 3 cycles until ack; then flush_o high exactly 2 cycles; mispred_cnt=1.
REQ-039 JALR pc=0x300, target=0x80 -> no is_branch_o, jump_pc_o=0x80, branch_cnt unchanged, mispred_cnt+1.
REQ-040 JAL pc=0x400, target=0x500, pred_taken=1, pred_target=0x480 -> feedback taken=1 target=0x500 and redirect to 0x500.
REQ-041 valid_i pulsed during REDIRECT, then rdy=0 for 4 cycles -> input discarded, outputs frozen, jump resumes identically.
REQ-042 rst=0 mid-FLUSH with counters at all-ones -> next edge IDLE, counters 0, flush_o=0, busy_o=0.
